// File: rtl/sseg_capture_pkg.sv
// -----------------------------------------------------------------------------
// sseg_capture_pkg
// Shared definitions for the 7-segment capture monitor:
//   - seg_t      : 7-bit segment pattern, [0]=a .. [6]=g, active-high
//   - GLYPH_*    : the only patterns the drive side is expected to show
//   - apair_e    : {Anode1, Anode2} encodings
//   - sample_t   : layout of the synchronized 9-bit input sample
//   - anode_pair : extracts the anode pair from a sample
// -----------------------------------------------------------------------------
package sseg_capture_pkg;

  typedef logic [6:0] seg_t;

  // Digit 1 shows the sensor state, digit 2 shows the switch state.
  localparam seg_t GLYPH_SNSA0 = 7'b0111111;
  localparam seg_t GLYPH_SNSA1 = 7'b0100011;
  localparam seg_t GLYPH_SW7_0 = 7'b0001110;
  localparam seg_t GLYPH_SW7_1 = 7'b0000011;

  // Encoded as {Anode1, Anode2}.
  typedef enum logic [1:0] {
    APAIR_NONE = 2'b00,
    APAIR_DIG2 = 2'b01,
    APAIR_DIG1 = 2'b10,
    APAIR_BOTH = 2'b11
  } apair_e;

  typedef struct packed {
    logic anode2;
    logic anode1;
    seg_t seg;
  } sample_t;

  localparam int SAMPLE_W = $bits(sample_t);

  function automatic apair_e anode_pair(input sample_t s);
    return apair_e'({s.anode1, s.anode2});
  endfunction

endpackage

// File: rtl/sseg_capture_if.sv
// -----------------------------------------------------------------------------
// sseg_capture_if
// Bundles the multiplexed segment bus seen by the monitor together with the
// monitor's readback results.
//   Bus (driven by the display path / board):
//     SSEG_Data[6:0], Anode1, Anode2
//   Results (driven by sseg_capture):
//     Dig1_Raw, Dig2_Raw, SnsA_Val, SnsA_Vld, SW7_Val, SW7_Vld,
//     Update, Stall, Fault
// Modports:
//   master : the side that drives the segment bus and reads the results
//   slave  : the capture monitor
// -----------------------------------------------------------------------------
interface sseg_capture_if;
  import sseg_capture_pkg::*;

  seg_t SSEG_Data;
  logic Anode1;
  logic Anode2;

  seg_t Dig1_Raw;
  seg_t Dig2_Raw;
  logic SnsA_Val;
  logic SnsA_Vld;
  logic SW7_Val;
  logic SW7_Vld;
  logic Update;
  logic Stall;
  logic Fault;

  modport master (
    output SSEG_Data, Anode1, Anode2,
    input  Dig1_Raw, Dig2_Raw, SnsA_Val, SnsA_Vld, SW7_Val, SW7_Vld,
           Update, Stall, Fault
  );

  modport slave (
    input  SSEG_Data, Anode1, Anode2,
    output Dig1_Raw, Dig2_Raw, SnsA_Val, SnsA_Vld, SW7_Val, SW7_Vld,
           Update, Stall, Fault
  );

endinterface

// File: rtl/sseg_sync2.sv
// -----------------------------------------------------------------------------
// sseg_sync2
// Two-flop synchronizer for a vector of independent asynchronous inputs.
// Each bit is synchronized on its own; no cross-bit coherence is implied,
// the caller must tolerate transient mixed samples.
// Ports:
//   clk_i : destination clock
//   rst_i : synchronous, active-high reset (both stages cleared)
//   d_i   : asynchronous input vector
//   q_o   : synchronized output vector
// -----------------------------------------------------------------------------
module sseg_sync2 #(
  parameter int DATA_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] meta_q;
  logic [DATA_W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sseg_capture.sv
// -----------------------------------------------------------------------------
// sseg_capture
// Readback monitor for the multiplexed 7-segment display. Synchronizes the
// segment bus, waits for each sample to be stable for STABLE_CYC cycles,
// then commits it into the digit register selected by the anodes and
// decodes the glyph back into the SnsA / SW7 bit it represents. Flags a
// stopped multiplexer (Stall) and an illegal anode combination (Fault).
// Ports:
//   CLK   : system clock, all state on rising edge
//   RST   : synchronous, active-high reset
//   bus   : sseg_capture_if.slave -- segment bus in, readback results out
// Parameters:
//   STABLE_CYC  : stable synchronized cycles required before a commit (>=1)
//   TIMEOUT_CYC : cycles without an Anode1 transition before Stall
//   TO_W        : timeout counter width, 2**TO_W > TIMEOUT_CYC
// -----------------------------------------------------------------------------
module sseg_capture
  import sseg_capture_pkg::*;
#(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 16
) (
  input  logic          CLK,
  input  logic          RST,
  sseg_capture_if.slave bus
);

  localparam int              ST_W    = $clog2(STABLE_CYC + 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STABLE_CYC);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STABLE_CYC - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  // ---- stage: input synchronization --------------------------------------
  logic [SAMPLE_W-1:0] raw_vec;
  logic [SAMPLE_W-1:0] samp_vec;
  sample_t             samp;

  assign raw_vec = {bus.Anode2, bus.Anode1, bus.SSEG_Data};

  sseg_sync2 #(
    .DATA_W (SAMPLE_W)
  ) u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (raw_vec),
    .q_o   (samp_vec)
  );

  assign samp = sample_t'(samp_vec);

  // ---- stage: stability, commit, decode, timeout -------------------------
  sample_t         prev_q,     prev_d;
  logic [ST_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [TO_W-1:0] to_cnt_q,   to_cnt_d;
  seg_t            dig1_q,     dig1_d;
  seg_t            dig2_q,     dig2_d;
  logic            snsa_val_q, snsa_val_d;
  logic            snsa_vld_q, snsa_vld_d;
  logic            sw7_val_q,  sw7_val_d;
  logic            sw7_vld_q,  sw7_vld_d;
  logic            upd_q,      upd_d;
  logic            stall_q,    stall_d;
  logic            fault_q,    fault_d;

  logic samp_chg;
  logic a1_chg;
  logic commit;
  logic to_evt;

  assign samp_chg = (samp != prev_q);
  assign a1_chg   = (samp.anode1 != prev_q.anode1);
  // Commit on the cycle the stability counter steps onto STABLE_CYC, so the
  // registered result appears together with the counter reaching its cap.
  // Once saturated the counter no longer matches ST_LAST: one commit/window.
  assign commit   = !samp_chg && (stab_cnt_q == ST_LAST);
  // Timeout fires once, on the step onto TIMEOUT_CYC.
  assign to_evt   = !a1_chg && (to_cnt_q == TO_LAST);

  always_comb begin
    prev_d     = samp;
    stab_cnt_d = stab_cnt_q;
    to_cnt_d   = to_cnt_q;
    dig1_d     = dig1_q;
    dig2_d     = dig2_q;
    snsa_val_d = snsa_val_q;
    snsa_vld_d = snsa_vld_q;
    sw7_val_d  = sw7_val_q;
    sw7_vld_d  = sw7_vld_q;
    upd_d      = 1'b0;
    stall_d    = stall_q;
    fault_d    = fault_q;

    if (samp_chg) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != ST_MAX) begin
      stab_cnt_d = stab_cnt_q + ST_W'(1);
    end

    if (a1_chg) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    if (commit) begin
      case (anode_pair(samp))
        APAIR_DIG1: begin
          dig1_d  = samp.seg;
          upd_d   = 1'b1;
          fault_d = 1'b0;
          if (samp.seg == GLYPH_SNSA0) begin
            snsa_val_d = 1'b0;
            snsa_vld_d = 1'b1;
          end else if (samp.seg == GLYPH_SNSA1) begin
            snsa_val_d = 1'b1;
            snsa_vld_d = 1'b1;
          end else begin
            snsa_vld_d = 1'b0;
          end
        end
        APAIR_DIG2: begin
          dig2_d  = samp.seg;
          upd_d   = 1'b1;
          fault_d = 1'b0;
          if (samp.seg == GLYPH_SW7_0) begin
            sw7_val_d = 1'b0;
            sw7_vld_d = 1'b1;
          end else if (samp.seg == GLYPH_SW7_1) begin
            sw7_val_d = 1'b1;
            sw7_vld_d = 1'b1;
          end else begin
            sw7_vld_d = 1'b0;
          end
        end
        default: begin
          // Both or neither anode lit: nothing to capture, only flag it.
          fault_d = 1'b1;
        end
      endcase
    end

    // Applied after the commit so a coincident timeout wins for Vld while
    // the raw capture and Update still go through.
    if (to_evt) begin
      stall_d    = 1'b1;
      snsa_vld_d = 1'b0;
      sw7_vld_d  = 1'b0;
    end else if (a1_chg) begin
      stall_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q     <= '0;
      stab_cnt_q <= '0;
      to_cnt_q   <= '0;
      dig1_q     <= '0;
      dig2_q     <= '0;
      snsa_val_q <= 1'b0;
      snsa_vld_q <= 1'b0;
      sw7_val_q  <= 1'b0;
      sw7_vld_q  <= 1'b0;
      upd_q      <= 1'b0;
      stall_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      stab_cnt_q <= stab_cnt_d;
      to_cnt_q   <= to_cnt_d;
      dig1_q     <= dig1_d;
      dig2_q     <= dig2_d;
      snsa_val_q <= snsa_val_d;
      snsa_vld_q <= snsa_vld_d;
      sw7_val_q  <= sw7_val_d;
      sw7_vld_q  <= sw7_vld_d;
      upd_q      <= upd_d;
      stall_q    <= stall_d;
      fault_q    <= fault_d;
    end
  end

  // ---- stage: outputs ----------------------------------------------------
  assign bus.Dig1_Raw = dig1_q;
  assign bus.Dig2_Raw = dig2_q;
  assign bus.SnsA_Val = snsa_val_q;
  assign bus.SnsA_Vld = snsa_vld_q;
  assign bus.SW7_Val  = sw7_val_q;
  assign bus.SW7_Vld  = sw7_vld_q;
  assign bus.Update   = upd_q;
  assign bus.Stall    = stall_q;
  assign bus.Fault    = fault_q;

endmodule

// File: tb/tb_sseg_capture.sv
// -----------------------------------------------------------------------------
// tb_sseg_capture
// Directed bench for sseg_capture at default parameters (STABLE_CYC=4,
// TIMEOUT_CYC=1024). Inputs change 1ns after a rising edge; that edge is
// cycle 0 of a phase. Outputs are sampled 1ns after edge N ("cycle N").
// Expected timing at defaults:
//   - commit/Update visible at cycle 7 of a phase (2 sync + 1 prev + 4 stable)
//   - synced Anode1 changes at cycle 2, its change is seen by the timeout
//     counter at edge 3, so Stall is first visible at cycle 3+1024 = 1027
//   - on resume, Stall clears at cycle 3
// -----------------------------------------------------------------------------
module tb_sseg_capture;

  logic CLK;
  logic RST;
  int   n_checks = 0;
  int   n_errors = 0;
  int   upd_cnt  = 0;

  sseg_capture_if bus ();

  sseg_capture #(
    .STABLE_CYC  (4),
    .TIMEOUT_CYC (1024),
    .TO_W        (16)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Update pulses are one cycle wide; counting on the falling edge sees each
  // exactly once.
  always @(negedge CLK) begin
    if (bus.Update === 1'b1) upd_cnt <= upd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic a1, input logic a2, input logic [6:0] seg);
    bus.Anode1    = a1;
    bus.Anode2    = a2;
    bus.SSEG_Data = seg;
  endtask

  // Holds one bus value for len cycles; checks Update stays low at cycle 6,
  // is exp_u at cycle 7, and the number of pulses in the window is exp_u.
  task automatic phase(input logic a1, input logic a2, input logic [6:0] seg,
                       input int len, input logic exp_u, input string tag);
    int u0;
    drive(a1, a2, seg);
    u0 = upd_cnt;
    for (int c = 1; c <= len; c++) begin
      tick();
      if (c == 6) check({tag, ".upd@6"}, 32'(bus.Update), 32'(1'b0));
      if (c == 7) check({tag, ".upd@7"}, 32'(bus.Update), 32'(exp_u));
    end
    check({tag, ".nupd"}, 32'(upd_cnt - u0), 32'(exp_u));
  endtask

  initial begin
    int u0;

    // ---- reset with arbitrary inputs ----
    RST = 1'b1;
    drive(1'b1, 1'b0, 7'h55);
    tick();
    check("rst.upd1", 32'(bus.Update), 32'd0);
    tick();
    check("rst.upd2", 32'(bus.Update), 32'd0);
    check("rst.dig1", 32'(bus.Dig1_Raw), 32'h00);
    check("rst.dig2", 32'(bus.Dig2_Raw), 32'h00);
    check("rst.flags", 32'({bus.SnsA_Val, bus.SnsA_Vld, bus.SW7_Val, bus.SW7_Vld,
                            bus.Update, bus.Stall, bus.Fault}), 32'd0);

    // ---- leave reset: 10/0x55 is a legal digit but not a SnsA glyph ----
    RST = 1'b0;
    u0 = upd_cnt;
    repeat (20) tick();
    check("boot.dig1", 32'(bus.Dig1_Raw), 32'h55);
    check("boot.snsa_vld", 32'(bus.SnsA_Vld), 32'd0);
    check("boot.nupd", 32'(upd_cnt - u0), 32'd1);
    check("boot.fault", 32'(bus.Fault), 32'd0);

    // ---- normal multiplex, two rounds ----
    for (int r = 0; r < 2; r++) begin
      phase(1'b1, 1'b0, 7'b0100011, 20, 1'b1, "mux.d1");
      check("mux.dig1", 32'(bus.Dig1_Raw), 32'h23);
      check("mux.snsa", 32'({bus.SnsA_Val, bus.SnsA_Vld}), 32'b11);
      phase(1'b0, 1'b1, 7'b0000011, 20, 1'b1, "mux.d2");
      check("mux.dig2", 32'(bus.Dig2_Raw), 32'h03);
      check("mux.sw7", 32'({bus.SW7_Val, bus.SW7_Vld}), 32'b11);
    end

    // ---- glitch reject: 3-cycle blip of SNSA1 inside a SNSA0 phase ----
    phase(1'b1, 1'b0, 7'b0111111, 20, 1'b1, "gl.base");
    check("gl.base.snsa", 32'({bus.SnsA_Val, bus.SnsA_Vld}), 32'b01);
    phase(1'b1, 1'b0, 7'b0100011, 3, 1'b0, "gl.blip");
    phase(1'b1, 1'b0, 7'b0111111, 20, 1'b1, "gl.rest");
    check("gl.dig1", 32'(bus.Dig1_Raw), 32'h3F);
    check("gl.snsa", 32'({bus.SnsA_Val, bus.SnsA_Vld}), 32'b01);

    // ---- unknown glyph on digit 2 ----
    phase(1'b0, 1'b1, 7'b1111111, 10, 1'b1, "unk");
    check("unk.dig2", 32'(bus.Dig2_Raw), 32'h7F);
    check("unk.sw7_vld", 32'(bus.SW7_Vld), 32'd0);
    check("unk.sw7_val", 32'(bus.SW7_Val), 32'd1);

    // ---- fault: both anodes lit ----
    phase(1'b1, 1'b1, 7'h2A, 10, 1'b0, "flt");
    check("flt.fault", 32'(bus.Fault), 32'd1);
    check("flt.dig1", 32'(bus.Dig1_Raw), 32'h3F);
    check("flt.dig2", 32'(bus.Dig2_Raw), 32'h7F);
    phase(1'b1, 1'b0, 7'b0111111, 10, 1'b1, "flt.rec");
    check("flt.rec.fault", 32'(bus.Fault), 32'd0);

    // ---- stall: park on digit 1 after a digit-2 phase ----
    phase(1'b0, 1'b1, 7'b0000011, 20, 1'b1, "pre");
    check("pre.sw7", 32'({bus.SW7_Val, bus.SW7_Vld}), 32'b11);
    drive(1'b1, 1'b0, 7'b0100011);
    for (int c = 1; c <= 1100; c++) begin
      tick();
      if (c == 7) check("stl.upd@7", 32'(bus.Update), 32'd1);
      if (c == 1026) begin
        check("stl.stall@1026", 32'(bus.Stall), 32'd0);
        check("stl.vld@1026", 32'({bus.SnsA_Vld, bus.SW7_Vld}), 32'b11);
      end
      if (c == 1027) begin
        check("stl.stall@1027", 32'(bus.Stall), 32'd1);
        check("stl.vld@1027", 32'({bus.SnsA_Vld, bus.SW7_Vld}), 32'b00);
      end
    end
    check("stl.vals", 32'({bus.SnsA_Val, bus.SW7_Val}), 32'b11);
    check("stl.raw", 32'({bus.Dig1_Raw, bus.Dig2_Raw}), 32'({7'b0100011, 7'b0000011}));
    check("stl.hold", 32'(bus.Stall), 32'd1);

    // ---- resume toggling ----
    drive(1'b0, 1'b1, 7'b0000011);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 2) check("res.stall@2", 32'(bus.Stall), 32'd1);
      if (c == 3) check("res.stall@3", 32'(bus.Stall), 32'd0);
      if (c == 7) check("res.upd@7", 32'(bus.Update), 32'd1);
    end
    check("res.vld", 32'({bus.SnsA_Vld, bus.SW7_Vld}), 32'b01);
    phase(1'b1, 1'b0, 7'b0100011, 20, 1'b1, "res.d1");
    check("res.vld2", 32'({bus.SnsA_Vld, bus.SW7_Vld}), 32'b11);
    check("res.stall", 32'(bus.Stall), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
